dxa_smem_responder: RTL

Shared-memory-side responder for the DXA tile-transfer engine. Accepts one element-granular shared-memory request per cycle (read, or byte-enabled write of one LSU word), performs it on a local word array, and returns exactly one in-order response per request: read data, or a write acknowledge. It sits between the DXA engine's smem request/response port and the shared-memory storage, and is also the bench model the engine's WAIT_RD/WAIT_WR states are verified against.

---
 rtl/dxa_smem_responder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dxa_smem_responder.sv
// rtl/dxa_smem_responder.sv - shared-memory word array with one in-order response per request
// Requests pass through a single access stage, then bypass to the output or wait in a small response queue.
module dxa_smem_responder #(
   parameter int WORD_SIZE = 8,
   parameter int NUM_WORDS = 1024,
   parameter int TAG_WIDTH = 8,
   parameter int RSP_DEPTH = 4,
   localparam int DATAW    = WORD_SIZE * 8,
   localparam int ADDRW    = $clog2(NUM_WORDS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   input  logic                 req_rw,
   input  logic [ADDRW-1:0]     req_addr,
   input  logic [WORD_SIZE-1:0] req_byteen,
   input  logic [DATAW-1:0]     req_data,
   input  logic [TAG_WIDTH-1:0] req_tag,
   output logic                 req_ready,
   output logic                 rsp_valid,
   output logic                 rsp_rw,
   output logic [DATAW-1:0]     rsp_data,
   output logic [TAG_WIDTH-1:0] rsp_tag,
   input  logic                 rsp_ready
);

   localparam int USEDW      = $clog2(RSP_DEPTH) + 1;
   localparam int CNTW       = $clog2(RSP_DEPTH);
   localparam int FIFO_DEPTH = RSP_DEPTH - 1;
   localparam int ENTW       = 1 + TAG_WIDTH + DATAW;

   localparam logic [USEDW-1:0] USED_MAX  = USEDW'(RSP_DEPTH);
   localparam logic [USEDW-1:0] USED_ONE  = USEDW'(1);
   localparam logic [CNTW-1:0]  CNT_FULL  = CNTW'(FIFO_DEPTH);
   localparam logic [CNTW-1:0]  CNT_ONE   = CNTW'(1);

   logic                 reset_q;
   logic [USEDW-1:0]     used;
   logic                 req_fire;
   logic                 rsp_fire;

   logic [DATAW-1:0]     mem [NUM_WORDS];
   logic [DATAW-1:0]     rd_word;

   logic                 st_valid;
   logic [ENTW-1:0]      st_ent;

   logic [ENTW-1:0]      fifo_ent [FIFO_DEPTH];
   logic [CNTW-1:0]      fifo_cnt;
   logic [CNTW-1:0]      fifo_wr_idx;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 st_bypass;
   logic                 st_leave;
   logic [ENTW-1:0]      out_ent;

   // Credit check uses only registered state, so acceptance never depends on the response side this cycle.
   assign req_ready = !reset && !reset_q && (used < USED_MAX);
   assign req_fire  = req_valid && req_ready;

   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == CNT_FULL);

   assign rsp_valid = fifo_empty ? st_valid : 1'b1;
   assign out_ent   = fifo_empty ? st_ent : fifo_ent[0];
   assign {rsp_rw, rsp_tag, rsp_data} = out_ent;
   assign rsp_fire  = rsp_valid && rsp_ready;

   // The stage either retires straight to the consumer or parks in the queue; credits guarantee room.
   assign fifo_pop    = rsp_fire && !fifo_empty;
   assign st_bypass   = st_valid && fifo_empty && rsp_ready;
   assign fifo_push   = st_valid && !st_bypass && (!fifo_full || fifo_pop);
   assign st_leave    = st_bypass || fifo_push;
   assign fifo_wr_idx = fifo_cnt - {{(CNTW-1){1'b0}}, fifo_pop};

   assign rd_word = req_rw ? '0 : mem[req_addr];

   always_ff @(posedge clk) begin
      if (reset) begin
         reset_q <= 1'b1;
         used    <= '0;
      end else begin
         reset_q <= 1'b0;
         case ({req_fire, rsp_fire})
            2'b10:   used <= used + USED_ONE;
            2'b01:   used <= used - USED_ONE;
            default: used <= used;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire && req_rw) begin
         for (int i = 0; i < WORD_SIZE; i++) begin
            if (req_byteen[i]) begin
               mem[req_addr][8*i +: 8] <= req_data[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_valid <= 1'b0;
         st_ent   <= '0;
      end else if (req_fire) begin
         st_valid <= 1'b1;
         st_ent   <= {req_rw, req_tag, rd_word};
      end else if (st_leave) begin
         st_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fifo_cnt <= '0;
      end else begin
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
            2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Head always sits at entry 0; a push lands behind whatever survives this cycle's pop.
   always_ff @(posedge clk) begin
      if (fifo_pop) begin
         for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
            fifo_ent[i] <= fifo_ent[i+1];
         end
      end
      if (fifo_push) begin
         fifo_ent[fifo_wr_idx] <= st_ent;
      end
   end

endmodule
